// File: rtl/systolic_pkg.sv
// Shared widths, feeder state encoding and packed-matrix element offsets
// for the 2x2 systolic array front end.
package systolic_pkg;

    localparam int unsigned DEF_DW           = 8;
    localparam int unsigned DEF_CW           = 18;
    localparam int unsigned DEF_DRAIN_CYCLES = 3;

    // Element slots in a packed 2x2 matrix {M11,M10,M01,M00}
    localparam int unsigned E00 = 0;
    localparam int unsigned E01 = 1;
    localparam int unsigned E10 = 2;
    localparam int unsigned E11 = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } feeder_state_e;

endpackage

// File: rtl/systolic_skew_2x2.sv
// Combinational selection of the diagonally skewed operands for one feed step.
module systolic_skew_2x2
    import systolic_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic            feed_en,
    input  logic [1:0]      feed_idx,
    input  logic [4*DW-1:0] a_mat,
    input  logic [4*DW-1:0] b_mat,
    output logic [DW-1:0]   a1_c,
    output logic [DW-1:0]   a2_c,
    output logic [DW-1:0]   b1_c,
    output logic [DW-1:0]   b2_c
);

    // Row i of A and column j of B enter i/j steps late
    always_comb begin
        a1_c = '0;
        a2_c = '0;
        b1_c = '0;
        b2_c = '0;
        if (feed_en) begin
            case (feed_idx)
                2'd0: begin
                    a1_c = a_mat[E00*DW +: DW];
                    b1_c = b_mat[E00*DW +: DW];
                end
                2'd1: begin
                    a1_c = a_mat[E01*DW +: DW];
                    a2_c = a_mat[E10*DW +: DW];
                    b1_c = b_mat[E10*DW +: DW];
                    b2_c = b_mat[E01*DW +: DW];
                end
                2'd2: begin
                    a2_c = a_mat[E11*DW +: DW];
                    b2_c = b_mat[E11*DW +: DW];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Job sequencer for the 2x2 output-stationary systolic array: accept a matrix
// pair, clear and feed the array, wait for drain, then hand out the results.
module systolic_feeder_2x2
    import systolic_pkg::*;
#(
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned CW           = DEF_CW,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] a_mat,
    input  logic [4*DW-1:0] b_mat,
    output logic            arr_clr,
    output logic [DW-1:0]   arr_a1,
    output logic [DW-1:0]   arr_a2,
    output logic [DW-1:0]   arr_b1,
    output logic [DW-1:0]   arr_b2,
    input  logic [CW-1:0]   arr_c11,
    input  logic [CW-1:0]   arr_c12,
    input  logic [CW-1:0]   arr_c21,
    input  logic [CW-1:0]   arr_c22,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*CW-1:0] c_mat
);

    // Shared feed/drain counter; must reach both 2 and DRAIN_CYCLES-1
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 4) ? $clog2(DRAIN_CYCLES) : 2;

    feeder_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4*DW-1:0]   a_lat_q, a_lat_d;
    logic [4*DW-1:0]   b_lat_q, b_lat_d;
    logic [4*CW-1:0]   c_mat_q, c_mat_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              arr_clr_q, arr_clr_d;
    logic [DW-1:0]     arr_a1_q, arr_a2_q, arr_b1_q, arr_b2_q;
    logic [DW-1:0]     arr_a1_d, arr_a2_d, arr_b1_d, arr_b2_d;
    logic              feed_en;
    logic [1:0]        feed_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_lat_q     <= '0;
            b_lat_q     <= '0;
            c_mat_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            arr_clr_q   <= 1'b1;
            arr_a1_q    <= '0;
            arr_a2_q    <= '0;
            arr_b1_q    <= '0;
            arr_b2_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_lat_q     <= a_lat_d;
            b_lat_q     <= b_lat_d;
            c_mat_q     <= c_mat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            arr_clr_q   <= arr_clr_d;
            arr_a1_q    <= arr_a1_d;
            arr_a2_q    <= arr_a2_d;
            arr_b1_q    <= arr_b1_d;
            arr_b2_q    <= arr_b2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_lat_d     = a_lat_q;
        b_lat_d     = b_lat_q;
        c_mat_d     = c_mat_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_lat_d = a_mat;
                    b_lat_d = b_mat;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (cnt_q == CNT_W'(2)) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    c_mat_d     = {arr_c22, arr_c21, arr_c12, arr_c11};
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
        arr_clr_d  = (state_d == ST_CLEAR);
    end

    // Operands are chosen from the upcoming state so they register in step with it
    assign feed_en  = (state_d == ST_FEED);
    assign feed_idx = 2'(cnt_d);

    systolic_skew_2x2 #(
        .DW (DW)
    ) u_skew (
        .feed_en  (feed_en),
        .feed_idx (feed_idx),
        .a_mat    (a_lat_q),
        .b_mat    (b_lat_q),
        .a1_c     (arr_a1_d),
        .a2_c     (arr_a2_d),
        .b1_c     (arr_b1_d),
        .b2_c     (arr_b2_d)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c_mat     = c_mat_q;
    assign arr_clr   = arr_clr_q;
    assign arr_a1    = arr_a1_q;
    assign arr_a2    = arr_a2_q;
    assign arr_b1    = arr_b1_q;
    assign arr_b2    = arr_b2_q;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench for systolic_feeder_2x2 with a behavioural 2x2 output-stationary array
// closing the loop between operand streams and accumulator inputs.
module tb_systolic_feeder_2x2;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 18;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4*DW-1:0] a_mat = '0;
    logic [4*DW-1:0] b_mat = '0;
    logic            arr_clr;
    logic [DW-1:0]   arr_a1, arr_a2, arr_b1, arr_b2;
    logic [CW-1:0]   arr_c11, arr_c12, arr_c21, arr_c22;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [4*CW-1:0] c_mat;

    int n_err = 0;
    int n_checks = 0;
    logic [4*CW-1:0] sb[$];

    always #5 clk = ~clk;

    systolic_feeder_2x2 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .arr_clr   (arr_clr),
        .arr_a1    (arr_a1),
        .arr_a2    (arr_a2),
        .arr_b1    (arr_b1),
        .arr_b2    (arr_b2),
        .arr_c11   (arr_c11),
        .arr_c12   (arr_c12),
        .arr_c21   (arr_c21),
        .arr_c22   (arr_c22),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_mat     (c_mat)
    );

    // Behavioural array: a flows right, b flows down, one register per hop
    logic signed [CW-1:0] pe11, pe12, pe21, pe22;
    logic [DW-1:0] a1_d, a2_d, b1_d, b2_d;

    function automatic logic [CW-1:0] mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return CW'(p);
    endfunction

    always @(posedge clk) begin
        if (arr_clr) begin
            pe11 <= '0; pe12 <= '0; pe21 <= '0; pe22 <= '0;
            a1_d <= '0; a2_d <= '0; b1_d <= '0; b2_d <= '0;
        end else begin
            pe11 <= pe11 + mul(arr_a1, arr_b1);
            pe12 <= pe12 + mul(a1_d, arr_b2);
            pe21 <= pe21 + mul(arr_a2, b1_d);
            pe22 <= pe22 + mul(a2_d, b2_d);
            a1_d <= arr_a1; a2_d <= arr_a2; b1_d <= arr_b1; b2_d <= arr_b2;
        end
    end
    assign arr_c11 = pe11;
    assign arr_c12 = pe12;
    assign arr_c21 = pe21;
    assign arr_c22 = pe22;

    function automatic logic [4*DW-1:0] pk8(input int e00, input int e01, input int e10, input int e11);
        return {DW'(e11), DW'(e10), DW'(e01), DW'(e00)};
    endfunction

    function automatic logic [4*CW-1:0] pk18(input int e00, input int e01, input int e10, input int e11);
        return {CW'(e11), CW'(e10), CW'(e01), CW'(e00)};
    endfunction

    task automatic chk(input string tag, input logic [4*CW-1:0] obs, input logic [4*CW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one job, track the response, and compare against the scoreboard
    task automatic send(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                        input logic [4*CW-1:0] exp, input bit chk_ops);
        logic [4*DW-1:0] ops[0:23];
        logic [4*CW-1:0] want;
        int n;
        chk("in_ready_idle", 72'(in_ready), 72'(1));
        in_valid = 1'b1;
        a_mat    = a;
        b_mat    = b;
        sb.push_back(exp);
        step();
        in_valid = 1'b0;
        a_mat    = 32'hA5A5_A5A5;
        b_mat    = 32'h5A5A_5A5A;
        chk("clr_in_clear", 72'(arr_clr), 72'(1));
        chk("in_ready_busy", 72'(in_ready), 72'(0));
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
            ops[n] = {arr_a1, arr_a2, arr_b1, arr_b2};
        end
        chk("latency", 72'(n), 72'(7));
        chk("out_valid_up", 72'(out_valid), 72'(1));
        if (chk_ops) begin
            chk("ops_f0", 72'(ops[1]), 72'({8'd1, 8'd0, 8'd5, 8'd0}));
            chk("ops_f1", 72'(ops[2]), 72'({8'd2, 8'd3, 8'd7, 8'd6}));
            chk("ops_f2", 72'(ops[3]), 72'({8'd0, 8'd4, 8'd0, 8'd8}));
            chk("ops_drain", 72'(ops[4]), 72'(0));
        end
        want = sb.pop_front();
        chk("c_mat", c_mat, want);
    endtask

    task automatic finish_job();
        step();
        chk("out_valid_drop", 72'(out_valid), 72'(0));
        chk("in_ready_after", 72'(in_ready), 72'(1));
    endtask

    initial begin
        logic [4*DW-1:0] ma, mb;
        logic [4*CW-1:0] c_first, c_bp;
        bit stable;
        int seen;

        ma      = pk8(1, 2, 3, 4);
        mb      = pk8(5, 6, 7, 8);
        c_first = pk18(19, 22, 43, 50);
        c_bp    = pk18(4, -5, 0, 9);

        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", 72'(in_ready), 72'(1));
        chk("rst_out_valid", 72'(out_valid), 72'(0));
        chk("rst_arr_clr", 72'(arr_clr), 72'(1));
        chk("rst_c_mat", c_mat, '0);
        chk("rst_ops", 72'({arr_a1, arr_a2, arr_b1, arr_b2}), 72'(0));
        step();
        step();
        rst = 1'b1;
        step();
        chk("idle_arr_clr", 72'(arr_clr), 72'(0));

        send(ma, mb, c_first, 1'b1);
        finish_job();

        send(pk8(-128, -128, -128, -128), pk8(-128, -128, -128, -128),
             pk18(32768, 32768, 32768, 32768), 1'b0);
        finish_job();
        send(pk8(-128, -128, -128, -128), pk8(127, 127, 127, 127),
             pk18(-32512, -32512, -32512, -32512), 1'b0);
        finish_job();

        send(pk8(1, 0, 0, 1), pk8(9, -3, 2, 7), pk18(9, -3, 2, 7), 1'b0);
        finish_job();
        send(pk8(1, 1, 1, 1), pk8(1, 1, 1, 1), pk18(2, 2, 2, 2), 1'b0);
        finish_job();

        out_ready = 1'b0;
        send(pk8(2, -1, 0, 3), pk8(2, -1, 0, 3), c_bp, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            a_mat    = pk8(7, 7, 7, 7);
            b_mat    = pk8(7, 7, 7, 7);
            step();
            if (out_valid !== 1'b1 || c_mat !== c_bp || in_ready !== 1'b0 || arr_clr !== 1'b0)
                stable = 1'b0;
        end
        chk("bp_stable", 72'(stable), 72'(1));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("bp_out_valid_drop", 72'(out_valid), 72'(0));
        chk("bp_in_ready", 72'(in_ready), 72'(1));
        chk("bp_no_accept", 72'(arr_clr), 72'(0));
        in_valid = 1'b0;
        step();
        chk("bp_still_idle", 72'(arr_clr), 72'(0));

        in_valid = 1'b1;
        a_mat    = ma;
        b_mat    = mb;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("abort_in_f1", 72'({arr_a1, arr_a2, arr_b1, arr_b2}), 72'({8'd2, 8'd3, 8'd7, 8'd6}));
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 72'(out_valid), 72'(0));
        chk("abort_in_ready", 72'(in_ready), 72'(1));
        chk("abort_arr_clr", 72'(arr_clr), 72'(1));
        chk("abort_ops", 72'({arr_a1, arr_a2, arr_b1, arr_b2}), 72'(0));
        chk("abort_c_mat", c_mat, '0);
        step();
        step();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        chk("abort_no_out", 72'(seen), 72'(0));
        send(ma, mb, c_first, 1'b1);
        finish_job();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
